// File: rtl/apb_rr_master_if.sv
// ---------------------------------------------------------------------------
// apb_rr_master_if
// APB bus bundle between the two-requester round-robin master and the shared
// APB segment.
//   PSEL, PENABLE, PWRITE  : transfer control, driven by the master
//   PADDR  [ADDR_W-1:0]    : byte address, driven by the master
//   PWDATA [DATA_W-1:0]    : write data, driven by the master
//   PREADY                 : slave ready / wait-state control, driven by the slave
//   PRDATA [DATA_W-1:0]    : read data, driven by the slave
// ---------------------------------------------------------------------------
interface apb_rr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
// Two-requester APB master. Arbitrates round-robin between two local
// requesters, runs the APB SETUP/ACCESS sequence for the winner and returns a
// one-cycle done pulse (plus read data or a watchdog error) to it. A PREADY
// watchdog aborts an ACCESS phase that stalls for TIMEOUT_CYCLES cycles
// (0 disables the watchdog).
// Ports:
//   PCLK, PRESETn                 : clock, async active-low reset
//   reqN_valid/write/addr/wdata   : request from requester N (held until done)
//   reqN_done/err/rdata           : completion pulse, abort flag, read data
//   apb (master modport)          : APB bus signals
// ---------------------------------------------------------------------------
module apb_rr_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,

  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_rdata,

  apb_rr_master_if.master   apb
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state;
  logic            grant;
  logic            last_grant;
  logic [WD_W-1:0] watchdog;

  logic            elig0;
  logic            elig1;
  logic            pick;
  logic            wd_hit;
  logic            finish;

  // A requester whose done pulse is high this cycle is still holding valid
  // for the just-completed transfer, so it is masked out of arbitration.
  assign elig0 = req0_valid && !req0_done;
  assign elig1 = req1_valid && !req1_done;

  // Round-robin choice: on contention the requester not served last wins;
  // otherwise whichever one is eligible (pick is only used when one is).
  always_comb begin
    pick = 1'b0;
    if (elig0 && elig1) begin
      pick = ~last_grant;
    end else begin
      pick = elig1;
    end
  end

  assign wd_hit = WD_EN && (watchdog == WD_LAST);
  assign finish = apb.PREADY || wd_hit;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      watchdog    <= '0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      req0_done   <= 1'b0;
      req0_err    <= 1'b0;
      req0_rdata  <= '0;
      req1_done   <= 1'b0;
      req1_err    <= 1'b0;
      req1_rdata  <= '0;
    end else begin
      req0_done <= 1'b0;
      req0_err  <= 1'b0;
      req1_done <= 1'b0;
      req1_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            grant       <= pick;
            last_grant  <= pick;
            apb.PADDR   <= pick ? req1_addr  : req0_addr;
            apb.PWRITE  <= pick ? req1_write : req0_write;
            apb.PWDATA  <= pick ? req1_wdata : req0_wdata;
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            state       <= SETUP;
          end
        end

        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
        end

        ACCESS: begin
          if (finish) begin
            // Normal completion or watchdog abort; an abort returns zero data
            // and a write completion leaves the last read data untouched.
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            watchdog    <= '0;
            state       <= IDLE;
            if (!grant) begin
              req0_done <= 1'b1;
              req0_err  <= !apb.PREADY;
              if (!apb.PREADY) begin
                req0_rdata <= '0;
              end else if (!apb.PWRITE) begin
                req0_rdata <= apb.PRDATA;
              end
            end else begin
              req1_done <= 1'b1;
              req1_err  <= !apb.PREADY;
              if (!apb.PREADY) begin
                req1_rdata <= '0;
              end else if (!apb.PWRITE) begin
                req1_rdata <= apb.PRDATA;
              end
            end
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          apb.PSEL    <= 1'b0;
          apb.PENABLE <= 1'b0;
          watchdog    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_master
// Directed-plus-random bench for apb_rr_master. Requests are kept in small
// per-requester arrays; the expected winner, access length, abort flag and
// read data are computed from the arbitration/timing rules, and the APB slave
// (PREADY/PRDATA) is played by the bench.
// ---------------------------------------------------------------------------
module tb_apb_rr_master;

  localparam int TMO = 16;

  logic        PCLK;
  logic        PRESETn;
  logic        req0_valid, req0_write, req0_done, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_done, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;

  apb_rr_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_rr_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_err(req0_err),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_err(req1_err),
    .req1_rdata(req1_rdata),
    .apb(bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Pending request per requester plus the slave behaviour for it.
  bit          r_valid [2];
  bit          r_wr    [2];
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];
  int          r_waits [2];
  logic [31:0] r_rdval [2];

  logic [31:0] exp_rd [2];
  int          model_last;
  int          got[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    return (w != 0) ? req1_done : req0_done;
  endfunction

  function automatic logic err_of(input int w);
    return (w != 0) ? req1_err : req0_err;
  endfunction

  function automatic logic [31:0] rdata_of(input int w);
    return (w != 0) ? req1_rdata : req0_rdata;
  endfunction

  task automatic drive();
    req0_valid = r_valid[0]; req0_write = r_wr[0];
    req0_addr  = r_addr[0];  req0_wdata = r_wdata[0];
    req1_valid = r_valid[1]; req1_write = r_wr[1];
    req1_addr  = r_addr[1];  req1_wdata = r_wdata[1];
  endtask

  // Random request; bit 12 of the address tags the requester so the winner
  // can be recognised on PADDR.
  task automatic new_req(input int w);
    logic [31:0] tmp;
    tmp        = $urandom();
    r_valid[w] = 1'b1;
    r_wr[w]    = 1'($urandom_range(0, 1));
    r_addr[w]  = (tmp & 32'hFFFF_EFFC) | ((w != 0) ? 32'h0000_1000 : 32'h0);
    r_wdata[w] = $urandom();
    r_waits[w] = $urandom_range(0, 3);
    r_rdval[w] = $urandom();
  endtask

  // Winner when arbitration next happens: alternate on contention.
  function automatic int pick();
    if (r_valid[0] && r_valid[1]) return (model_last == 0) ? 1 : 0;
    return r_valid[1] ? 1 : 0;
  endfunction

  // Follows one transfer from the negedge before its grant edge to its done
  // cycle, playing the slave and checking every phase.
  task automatic phases(input int w);
    int          o;
    bit          abort;
    int          ncyc;
    logic [31:0] a;
    o     = 1 - w;
    abort = (r_waits[w] >= TMO);
    ncyc  = abort ? TMO : r_waits[w] + 1;
    a     = r_addr[w];

    @(negedge PCLK);
    check("setup_psel",    bus.PSEL, 32'd1);
    check("setup_penable", bus.PENABLE, 32'd0);
    check("setup_paddr",   bus.PADDR, a);
    check("setup_pwrite",  bus.PWRITE, 32'(r_wr[w]));
    if (r_wr[w]) check("setup_pwdata", bus.PWDATA, r_wdata[w]);
    check("setup_done",    {req0_done, req1_done}, 32'd0);
    got.push_back((bus.PADDR === r_addr[1]) ? 1 : 0);

    for (int k = 0; k < ncyc; k++) begin
      @(negedge PCLK);
      check("access_psel",    bus.PSEL, 32'd1);
      check("access_penable", bus.PENABLE, 32'd1);
      check("access_paddr",   bus.PADDR, a);
      check("access_done",    {req0_done, req1_done}, 32'd0);
      if (k >= r_waits[w]) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = r_rdval[w];
      end else begin
        bus.PREADY = 1'b0;
        bus.PRDATA = $urandom();
      end
    end

    @(negedge PCLK);
    bus.PREADY = 1'b0;
    if (abort) exp_rd[w] = 32'h0;
    else if (!r_wr[w]) exp_rd[w] = r_rdval[w];
    check("done_winner",  32'(done_of(w)), 32'd1);
    check("done_other",   32'(done_of(o)), 32'd0);
    check("err_winner",   32'(err_of(w)), 32'(abort));
    check("rdata_winner", rdata_of(w), exp_rd[w]);
    check("rdata_other",  rdata_of(o), exp_rd[o]);
    check("done_psel",    {bus.PSEL, bus.PENABLE}, 32'd0);
  endtask

  // Serves all pending requests; the first n_reissue winners immediately
  // present a fresh request instead of dropping valid.
  task automatic serve(input int n_reissue);
    int n;
    int w;
    int guard;
    n     = n_reissue;
    guard = 0;
    while ((r_valid[0] || r_valid[1]) && guard < 20) begin
      guard++;
      w          = pick();
      model_last = w;
      phases(w);
      if (n > 0) begin
        n--;
        new_req(w);
      end else begin
        r_valid[w] = 1'b0;
      end
      drive();
    end
    @(negedge PCLK);
    check("idle_psel", bus.PSEL, 32'd0);
    check("idle_done", {req0_done, req1_done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
      r_waits[i] = 0; r_rdval[i] = '0; exp_rd[i] = '0;
    end
    model_last = 1;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    drive();
    PRESETn = 1'b0;

    // Reset state.
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_psel_penable", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 32'd0);
    check("rst_paddr",  bus.PADDR, 32'd0);
    check("rst_pwdata", bus.PWDATA, 32'd0);
    check("rst_done_err", {req0_done, req0_err, req1_done, req1_err}, 32'd0);
    check("rst_rdata0", req0_rdata, 32'd0);
    check("rst_rdata1", req1_rdata, 32'd0);
    PRESETn = 1'b1;

    // Single read by requester 0, zero wait states.
    @(negedge PCLK);
    r_valid[0] = 1'b1; r_wr[0] = 1'b0; r_addr[0] = 32'h10; r_wdata[0] = 32'h0;
    r_waits[0] = 0; r_rdval[0] = 32'hDEADBEEF;
    drive();
    serve(0);
    check("single_read_rdata", req0_rdata, 32'hDEADBEEF);

    // Single write by requester 1.
    r_valid[1] = 1'b1; r_wr[1] = 1'b1; r_addr[1] = 32'h24; r_wdata[1] = 32'h12345678;
    r_waits[1] = 0; r_rdval[1] = 32'h0;
    drive();
    serve(0);

    // Contention: both held valid for four transfers.
    got.delete();
    new_req(0); new_req(1);
    drive();
    serve(2);
    check("rr_count", got.size(), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check($sformatf("rr_order%0d", i), got[i], 32'(i % 2));
    end

    // Wait states: PREADY low for three ACCESS cycles.
    new_req(0);
    r_wr[0] = 1'b0; r_waits[0] = 3;
    drive();
    serve(0);

    // Stuck slave: watchdog abort, then the other pending request proceeds.
    new_req(0); new_req(1);
    r_waits[pick()] = 100;
    r_waits[1 - pick()] = 0;
    drive();
    serve(0);

    // Randomized mix of single and contending requests.
    for (int it = 0; it < 6; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      if (pat[0]) new_req(0);
      if (pat[1]) new_req(1);
      drive();
      serve(0);
    end

    // Reset during ACCESS: bus drops at once, no done, req0 wins afterwards.
    new_req(1);
    r_valid[0] = 1'b0; r_waits[1] = 100;
    drive();
    @(negedge PCLK);
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_rst_penable", bus.PENABLE, 32'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_async_bus", {bus.PSEL, bus.PENABLE}, 32'd0);
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    drive();
    for (int k = 0; k < 2; k++) begin
      @(negedge PCLK);
      check("rst_no_done", {req0_done, req1_done}, 32'd0);
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    model_last = 1;
    got.delete();
    new_req(0); new_req(1);
    drive();
    PRESETn = 1'b1;
    serve(0);
    check("post_rst_first_grant", (got.size() > 0) ? got[0] : 32'd99, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Two-requester APB master: arbitrates round-robin between two local requesters, sequences the APB SETUP/ACCESS phases and returns read data or completion to the winner.
- Sits between on-chip initiators (e.g. bridge front-end, DMA/config engine) and the shared APB segment of 32-bit word-addressed slaves.
- Includes a PREADY wait-state watchdog so a hung slave cannot lock the bus.

Parameters:
ADDR_W, 32, PADDR and request address width
DATA_W, 32, PWDATA/PRDATA and request data width
TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables watchdog

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  async active-low reset
req0_valid  in  1  requester 0 transfer request, held until req0_done
req0_write  in  1  1=write, 0=read; stable while valid
req0_addr  in  ADDR_W  byte address; stable while valid
req0_wdata  in  DATA_W  write data; stable while valid
req0_done  out  1  one-cycle completion pulse
req0_err  out  1  valid with done: 1=watchdog abort
req0_rdata  out  DATA_W  read data, valid with done
req1_*  same set as req0_* for requester 1
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data

Behaviour:
- Reset: PRESETn async, active-low; clock PCLK. All outputs registered; reset: PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, reqN_done=reqN_err=0, reqN_rdata=0, state=IDLE, last_grant=1 (req0 wins first), watchdog=0.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE: eligible_N = reqN_valid && !reqN_done. No eligible requester: stay. One eligible: grant it. Both eligible: grant the one != last_grant. On grant: latch grant, PADDR/PWRITE/PWDATA from winner, PSEL=1, PENABLE=0, -> SETUP, last_grant<=grant.
- SETUP: one cycle; PENABLE<=1, -> ACCESS.
- ACCESS: PADDR/PWRITE/PWDATA/PSEL held.
  - PREADY=1: PSEL<=0, PENABLE<=0, req[grant]_done<=1, err<=0; read: rdata<=PRDATA; write: rdata unchanged. -> IDLE.
  - PREADY=0: watchdog++. If TIMEOUT_CYCLES!=0 and watchdog==TIMEOUT_CYCLES-1: abort, same as completion but err=1, rdata<=0. Watchdog cleared on leaving ACCESS.
- done/err: one-cycle pulses (high the cycle after completion edge). Requester drops or changes valid on the edge where it samples done=1. The !done mask stops re-grant of the just-served request.
- Minimum latency: valid in IDLE cycle 0 -> PSEL cycle 1 -> PENABLE cycle 2 -> done cycle 3 (zero wait states). Back-to-back throughput: one transfer per 3 cycles.
- The non-granted requester is stalled with no effect on its outputs. A valid drop mid-transfer is a protocol violation; the transfer still completes.
- Watchdog abort: the done=1 cycle is IDLE with PSEL=0, so new arbitration proceeds normally.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, no done issued, last_grant=1.

Test Plan:
- Single read, req0 addr 0x10, PREADY=1, PRDATA=0xDEADBEEF: PSEL@1, PENABLE@2, req0_done=1, rdata=0xDEADBEEF, err=0 @3.
- Single write, req1 addr 0x24 data 0x12345678: PADDR=0x24, PWRITE=1, PWDATA=0x12345678 across SETUP/ACCESS; req1_done @3.
- Both requesters held valid for 4 transfers: grant order 0,1,0,1; no requester served twice consecutively; each done exactly once per request.
- Wait states, PREADY low 3 ACCESS cycles then high: PSEL/PENABLE/PADDR stable for 4 ACCESS cycles; done 1 cycle after PREADY sampled high; err=0.
- PREADY stuck low, TIMEOUT_CYCLES=16: abort after 16 ACCESS cycles, err=1, rdata=0; next pending request then granted normally.
- PRESETn asserted during ACCESS: PSEL=PENABLE=0 immediately, no done; after release, req0 wins a simultaneous request.
